// File: rtl/cap_bounds_monitor_pkg.sv
// Shared definitions for the capability bounds monitor: cause-bit indices
// of a failed check and the two-state run/halt controller encoding.
package cap_bounds_monitor_pkg;

  // Bit positions inside a 4-bit fail code
  localparam int FC_BASE_LO = 0;  // derived base below parent base
  localparam int FC_TOP_HI  = 1;  // derived top above parent top
  localparam int FC_REQ_OUT = 2;  // request not covered by derived bounds, or inverted bounds
  localparam int FC_INEXACT = 3;  // exact bounds demanded but not delivered
  localparam int FC_W       = 4;

  // Controller state, kept as plain constants for legacy tools
  typedef logic [0:0] state_t;
  localparam state_t ST_RUN  = 1'b0;
  localparam state_t ST_HALT = 1'b1;

endpackage

// File: rtl/cap_bounds_check.sv
// Single-channel bounds compare. Purely combinational; all compares are
// unsigned, tops are one bit wider than bases so a top of 2^XLEN is legal.
module cap_bounds_check
  import cap_bounds_monitor_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] old_base,
  input  logic [XLEN:0]   old_top,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN:0]   req_top,
  input  logic [XLEN-1:0] new_base,
  input  logic [XLEN:0]   new_top,
  input  logic            exact,
  output logic [FC_W-1:0] code
);

  // Derive each cause bit independently so several can be reported at once
  always_comb begin
    code             = '0;
    code[FC_BASE_LO] = new_base < old_base;
    code[FC_TOP_HI]  = new_top > old_top;
    code[FC_REQ_OUT] = (req_base < new_base) || (req_top > new_top) ||
                       ({1'b0, new_base} > new_top);
    code[FC_INEXACT] = exact && ((new_base != req_base) || (new_top != req_top));
  end

endmodule

// File: rtl/cap_bounds_monitor.sv
// Multi-channel capability bounds monitor. Stage 1 captures accepted
// operands, stage 2 compares them and updates the sticky failure record,
// saturating counters and the run/halt controller.
module cap_bounds_monitor
  import cap_bounds_monitor_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NCHAN        = 4,
  parameter int CNT_W        = 32,
  parameter int HALT_ON_FAIL = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NCHAN-1:0]          in_valid,
  output logic [NCHAN-1:0]          in_ready,
  input  logic [NCHAN*XLEN-1:0]     in_old_base,
  input  logic [NCHAN*(XLEN+1)-1:0] in_old_top,
  input  logic [NCHAN*XLEN-1:0]     in_req_base,
  input  logic [NCHAN*(XLEN+1)-1:0] in_req_top,
  input  logic [NCHAN*XLEN-1:0]     in_new_base,
  input  logic [NCHAN*(XLEN+1)-1:0] in_new_top,
  input  logic [NCHAN-1:0]          in_exact,
  input  logic                      clear,
  output logic                      fail,
  output logic [2:0]                fail_chan,
  output logic [3:0]                fail_code,
  output logic [CNT_W-1:0]          check_count,
  output logic [CNT_W-1:0]          fail_count,
  output logic                      halted
);

  localparam int TW = XLEN + 1;

  function automatic logic [3:0] popcount(input logic [NCHAN-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NCHAN; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0]       b);
    logic [CNT_W+3:0] sum;
    sum = {4'b0000, a} + {{CNT_W{1'b0}}, b};
    if (sum[CNT_W+3:CNT_W] != 4'b0000) return '1;
    return sum[CNT_W-1:0];
  endfunction

  state_t                    state, state_nx;
  logic [NCHAN-1:0]          vld_p1;
  logic [NCHAN*XLEN-1:0]     old_base_p1, req_base_p1, new_base_p1;
  logic [NCHAN*TW-1:0]       old_top_p1, req_top_p1, new_top_p1;
  logic [NCHAN-1:0]          exact_p1;
  logic [FC_W-1:0]           chk_code [NCHAN];
  logic [NCHAN-1:0]          chk_fail;
  logic [2:0]                first_chan;
  logic [FC_W-1:0]           first_code;
  logic                      take_fail;

  // Acceptance depends only on reset and controller state
  assign in_ready = {NCHAN{RST_N && (state == ST_RUN)}};
  assign halted   = (state == ST_HALT);

  // Stage 1: capture operands of accepted channels (data, no reset)
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        old_base_p1[i*XLEN +: XLEN] <= in_old_base[i*XLEN +: XLEN];
        req_base_p1[i*XLEN +: XLEN] <= in_req_base[i*XLEN +: XLEN];
        new_base_p1[i*XLEN +: XLEN] <= in_new_base[i*XLEN +: XLEN];
        old_top_p1[i*TW +: TW]      <= in_old_top[i*TW +: TW];
        req_top_p1[i*TW +: TW]      <= in_req_top[i*TW +: TW];
        new_top_p1[i*TW +: TW]      <= in_new_top[i*TW +: TW];
        exact_p1[i]                 <= in_exact[i];
      end
    end
  end

  // Stage 1: valid bits, flushed by reset so in-flight checks are dropped
  always_ff @(posedge CLK) begin
    if (!RST_N) vld_p1 <= '0;
    else        vld_p1 <= in_valid & in_ready;
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_chk
    cap_bounds_check #(.XLEN(XLEN)) u_chk (
      .old_base (old_base_p1[g*XLEN +: XLEN]),
      .old_top  (old_top_p1[g*TW +: TW]),
      .req_base (req_base_p1[g*XLEN +: XLEN]),
      .req_top  (req_top_p1[g*TW +: TW]),
      .new_base (new_base_p1[g*XLEN +: XLEN]),
      .new_top  (new_top_p1[g*TW +: TW]),
      .exact    (exact_p1[g]),
      .code     (chk_code[g])
    );
    assign chk_fail[g] = vld_p1[g] && (|chk_code[g]);
  end

  // Stage 2: pick the lowest-index failing channel
  always_comb begin
    first_chan = '0;
    first_code = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (chk_fail[i]) begin
        first_chan = 3'(i);
        first_code = chk_code[i];
      end
    end
  end

  // A failure is recorded when none is held, or when it collides with clear
  assign take_fail = (|chk_fail) && (!fail || clear);

  // Stage 2: next controller state; a recorded failure beats clear
  always_comb begin
    state_nx = state;
    if (take_fail && (HALT_ON_FAIL != 0)) state_nx = ST_HALT;
    else if (clear)                       state_nx = ST_RUN;
  end

  // Stage 2: controller state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_RUN;
    else        state <= state_nx;
  end

  // Stage 2: sticky failure record
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fail      <= 1'b0;
      fail_chan <= '0;
      fail_code <= '0;
    end else if (take_fail) begin
      fail      <= 1'b1;
      fail_chan <= first_chan;
      fail_code <= first_code;
    end else if (clear) begin
      fail      <= 1'b0;
      fail_chan <= '0;
      fail_code <= '0;
    end
  end

  // Stage 2: saturating check and failure counters
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      check_count <= '0;
      fail_count  <= '0;
    end else begin
      check_count <= sat_add(check_count, popcount(vld_p1));
      fail_count  <= sat_add(fail_count, popcount(chk_fail));
    end
  end

endmodule
